mem_wb_skid_reg: RTL and testbench
==================================

# mem_wb_skid_reg

Parametrised MEM→WB pipeline register with a valid/ready handshake and a two-entry skid buffer. It holds the memory-stage results (write-back enable, memory-read select, destination register, PC, ALU result, memory data) between the memory and write-back stages. It adds stall back-pressure, flush, bubble squashing and an optional forwarding tap. Full throughput is kept while `in_ready` stays a registered signal.

## Interface
- `DATA_W`, 32, width of `ALU_result` and `Mem_Data`
- `PC_W`, 32, width of `PC`
- `REG_ADDR_W`, 5, width of `dest`
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: synchronous, active-low reset
- `flush` in 1: discard all held and incoming entries
- `in_valid` in 1: upstream entry present
- `in_ready` out 1: block accepts an entry this cycle
- `WB_En_in`, `MEM_R_En_in` in 1 each: control fields
- `dest_in` in REG_ADDR_W; `PC_in` in PC_W; `ALU_result_in`, `Mem_Data_in` in DATA_W
- `out_valid` out 1: output entry present
- `out_ready` in 1: write-back consumes the entry
- `WB_En`, `MEM_R_En` out 1 each; `dest` out REG_ADDR_W; `PC` out PC_W; `ALU_result`, `Mem_Data` out DATA_W
- `fwd_valid` out 1, `fwd_dest` out REG_ADDR_W, `fwd_value` out DATA_W: present only with `MEM_WB_FWD_EN`

## Operation
- **Transfers.** An input transfer happens when `in_valid & in_ready`. An output transfer happens when `out_valid & out_ready`.
- **Storage.** Two slots: main (drives outputs) and skid.
- **States:**
  - EMPTY: no valid slot.
  - ONE: main valid.
  - FULL: main and skid valid.
- **Transitions (no flush):**
  - EMPTY: input transfer → ONE, main loaded.
  - ONE, input and output transfer → ONE, main reloaded.
  - ONE, output transfer only → EMPTY.
  - ONE, input transfer only → FULL, skid loaded.
  - ONE, neither → hold.
  - FULL: `out_ready` → ONE, main ← skid. Otherwise hold.
- **Ready.** `in_ready` = (state ≠ FULL) and rst high. It is a function of registered state only and never depends combinationally on `out_ready`.
- **Outputs.** `out_valid` = (state ≠ EMPTY).
- **Bubble squash.**
  - `WB_En` output = main.WB_En & `out_valid` & (main.dest ≠ 0). Writes to register 0 are dropped.
  - `MEM_R_En` output is gated by `out_valid` in the same way.
  - Data fields hold their last loaded value when invalid.
- **Flush.**
  - A flush sampled high moves the block to EMPTY on the next edge.
  - It wins over any simultaneous input or output transfer; the input entry of that cycle is dropped.
  - `in_ready` is unaffected by `flush` in the flush cycle.
- **Reset.**
  - While `rst` is low, on each edge: state EMPTY and all slot fields zero.
  - Outputs during reset: `out_valid`=0, `in_ready`=0, `WB_En`=0, `MEM_R_En`=0, `dest`=0, `PC`=0, `ALU_result`=0, `Mem_Data`=0.
  - Reset mid-transfer discards both slots.
- **Width rule.** Fields are copied unmodified. No arithmetic is performed.

## Timing
- **Latency.** One cycle from an input transfer into EMPTY to `out_valid`.
- **Throughput.** One entry per cycle while `out_ready` is held high.
- **Back-pressure.**
  - With `out_ready` low, a second entry is accepted into skid.
  - `in_ready` falls on the following edge.
  - The skid entry is presented one cycle after `out_ready` rises.
  - `in_ready` rises on that same edge.
- **Ordering.** FIFO ordering is guaranteed. No entry is duplicated or lost except by flush or reset.

## Configuration
- **`MEM_WB_FWD_EN` defined:** forwarding ports exist and are combinational from main.
  - `fwd_valid` = squashed `WB_En`.
  - `fwd_dest` = main.dest.
  - `fwd_value` = main.MEM_R_En ? main.Mem_Data : main.ALU_result.
- **`MEM_WB_FWD_EN` undefined:** the ports and their logic are absent. All other behaviour is identical.

## Structure
- **Package `mem_wb_pkg`:**
  - packed struct `mem_wb_t`: `WB_En`, `MEM_R_En`, `dest`, `PC`, `ALU_result`, `Mem_Data`.
  - state enum `mem_wb_state_e`: EMPTY, ONE, FULL.
  - Default width localparams for DATA_W, PC_W and REG_ADDR_W.
- **Sub-module `mem_wb_slot`:** one payload register with load enable and synchronous active-low clear. Instantiated twice, for main and skid.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with `in_valid`=1 → all outputs 0 and `in_ready`=0. After release, `in_ready`=1 and `out_valid`=0.
- **Streaming.** `out_ready`=1; PC 0x100, 0x104, 0x108 on consecutive cycles → the same PCs appear on `PC` one cycle later each, with `out_valid` continuous.
- **Back-pressure.**
  - Step 1: `out_ready`=0; present ALU_result 0xA, then 0xB → `in_ready` drops after 0xB is accepted; output holds 0xA.
  - Step 2: raise `out_ready` → 0xA, then 0xB are delivered; `in_ready` returns to 1.
- **Flush.** Flush in FULL, with `in_valid`=1 carrying dest 7 → next cycle `out_valid`=0 and `WB_En`=0; the dest 7 entry never appears.
- **Register-0 squash.** `WB_En_in`=1, `dest_in`=0 → `out_valid`=1 and `WB_En`=0.
- **Forwarding (`MEM_WB_FWD_EN`).** `MEM_R_En_in`=1, `Mem_Data_in`=0x55, `ALU_result_in`=0x33, `dest_in`=4 → `fwd_value`=0x55, `fwd_dest`=4, `fwd_valid`=1.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM->WB pipeline register.
package mem_wb_pkg;

  localparam int MEM_WB_DATA_W     = 32;
  localparam int MEM_WB_PC_W       = 32;
  localparam int MEM_WB_REG_ADDR_W = 5;

  typedef struct packed {
    logic                         WB_En;
    logic                         MEM_R_En;
    logic [MEM_WB_REG_ADDR_W-1:0] dest;
    logic [MEM_WB_PC_W-1:0]       PC;
    logic [MEM_WB_DATA_W-1:0]     ALU_result;
    logic [MEM_WB_DATA_W-1:0]     Mem_Data;
  } mem_wb_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// MEM->WB handshake bundle; slave = pipeline register, master = its environment.
// Forwarding tap signals exist only when MEM_WB_FWD_EN is defined.
interface mem_wb_skid_reg_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = MEM_WB_DATA_W,
  parameter int PC_W       = MEM_WB_PC_W,
  parameter int REG_ADDR_W = MEM_WB_REG_ADDR_W
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  WB_En_in;
  logic                  MEM_R_En_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [PC_W-1:0]       PC_in;
  logic [DATA_W-1:0]     ALU_result_in;
  logic [DATA_W-1:0]     Mem_Data_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  WB_En;
  logic                  MEM_R_En;
  logic [REG_ADDR_W-1:0] dest;
  logic [PC_W-1:0]       PC;
  logic [DATA_W-1:0]     ALU_result;
  logic [DATA_W-1:0]     Mem_Data;
`ifdef MEM_WB_FWD_EN
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_dest;
  logic [DATA_W-1:0]     fwd_value;
`endif

  modport slave (
    input  flush, in_valid, WB_En_in, MEM_R_En_in, dest_in, PC_in,
           ALU_result_in, Mem_Data_in, out_ready,
`ifdef MEM_WB_FWD_EN
    output fwd_valid, fwd_dest, fwd_value,
`endif
    output in_ready, out_valid, WB_En, MEM_R_En, dest, PC, ALU_result, Mem_Data
  );

  modport master (
    output flush, in_valid, WB_En_in, MEM_R_En_in, dest_in, PC_in,
           ALU_result_in, Mem_Data_in, out_ready,
`ifdef MEM_WB_FWD_EN
    input  fwd_valid, fwd_dest, fwd_value,
`endif
    input  in_ready, out_valid, WB_En, MEM_R_En, dest, PC, ALU_result, Mem_Data
  );

endinterface

// File: rtl/mem_wb_slot.sv
// One payload register: load enable, synchronous active-low clear to zero.
// Latency 1 cycle from ld to q; no handshake of its own.
module mem_wb_slot
  import mem_wb_pkg::*;
#(
  parameter type T = mem_wb_t
) (
  input  logic clk,
  input  logic clr_n,
  input  logic ld,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with two-entry skid; 1-cycle latency, full throughput.
// in_ready is registered-state only (low when FULL); optional MEM_WB_FWD_EN forwarding tap.
module mem_wb_skid_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = MEM_WB_DATA_W,
  parameter int PC_W       = MEM_WB_PC_W,
  parameter int REG_ADDR_W = MEM_WB_REG_ADDR_W
) (
  input logic             clk,
  input logic             rst,
  mem_wb_skid_reg_if.slave bus
);

  typedef struct packed {
    logic                  WB_En;
    logic                  MEM_R_En;
    logic [REG_ADDR_W-1:0] dest;
    logic [PC_W-1:0]       PC;
    logic [DATA_W-1:0]     ALU_result;
    logic [DATA_W-1:0]     Mem_Data;
  } slot_t;

  mem_wb_state_e state_q, state_d;
  slot_t         in_entry, main_d, main_q, skid_q;
  logic          main_ld, skid_ld, main_from_skid;
  logic          in_xfer, out_xfer;

  assign in_entry = '{WB_En:      bus.WB_En_in,
                      MEM_R_En:   bus.MEM_R_En_in,
                      dest:       bus.dest_in,
                      PC:         bus.PC_in,
                      ALU_result: bus.ALU_result_in,
                      Mem_Data:   bus.Mem_Data_in};

  assign bus.in_ready  = (state_q != FULL) && rst;
  assign bus.out_valid = (state_q != EMPTY);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_ld = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d        = ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including this cycle's input; slot data is left untouched.
    if (bus.flush) begin
      state_d = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  mem_wb_slot #(.T(slot_t)) u_main (
    .clk   (clk),
    .clr_n (rst),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  mem_wb_slot #(.T(slot_t)) u_skid (
    .clk   (clk),
    .clr_n (rst),
    .ld    (skid_ld),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Register 0 is hard-wired, so a write to it is squashed to a bubble.
  assign bus.WB_En      = main_q.WB_En && bus.out_valid && (main_q.dest != '0);
  assign bus.MEM_R_En   = main_q.MEM_R_En && bus.out_valid;
  assign bus.dest       = main_q.dest;
  assign bus.PC         = main_q.PC;
  assign bus.ALU_result = main_q.ALU_result;
  assign bus.Mem_Data   = main_q.Mem_Data;

`ifdef MEM_WB_FWD_EN
  assign bus.fwd_valid = bus.WB_En;
  assign bus.fwd_dest  = main_q.dest;
  assign bus.fwd_value = main_q.MEM_R_En ? main_q.Mem_Data : main_q.ALU_result;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: reset, streaming, back-pressure, flush, squash, forwarding.
module tb_mem_wb_skid_reg;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_wb_skid_reg_if #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5)) bus ();

  mem_wb_skid_reg #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr, input logic [4:0] d,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] md);
    bus.in_valid      = v;
    bus.WB_En_in      = wb;
    bus.MEM_R_En_in   = mr;
    bus.dest_in       = d;
    bus.PC_in         = pc;
    bus.ALU_result_in = alu;
    bus.Mem_Data_in   = md;
  endtask

  initial begin
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'hDEAD, 32'h1234, 32'h5678);
    @(negedge clk);

    // Reset held 3 cycles with input offered
    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_WB_En",     64'(bus.WB_En),     64'd0);
    chk("rst_MEM_R_En",  64'(bus.MEM_R_En),  64'd0);
    chk("rst_dest",      64'(bus.dest),      64'd0);
    chk("rst_PC",        64'(bus.PC),        64'd0);
    chk("rst_ALU",       64'(bus.ALU_result), 64'd0);
    chk("rst_Mem_Data",  64'(bus.Mem_Data),  64'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Streaming with out_ready held high
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h100, 32'h0, 32'h0);
    tick();
    chk("stream_v0",  64'(bus.out_valid), 64'd1);
    chk("stream_pc0", 64'(bus.PC), 64'h100);
    chk("stream_wb0", 64'(bus.WB_En), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h104, 32'h0, 32'h0);
    tick();
    chk("stream_v1",  64'(bus.out_valid), 64'd1);
    chk("stream_pc1", 64'(bus.PC), 64'h104);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h108, 32'h0, 32'h0);
    tick();
    chk("stream_v2",  64'(bus.out_valid), 64'd1);
    chk("stream_pc2", 64'(bus.PC), 64'h108);
    chk("stream_rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("stream_drain_v", 64'(bus.out_valid), 64'd0);

    // Back-pressure: second entry goes to skid
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h200, 32'hA, 32'h0);
    tick();
    chk("bp_a_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_a_alu",   64'(bus.ALU_result), 64'hA);
    chk("bp_a_rdy",   64'(bus.in_ready), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h204, 32'hB, 32'h0);
    tick();
    chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
    chk("bp_full_alu", 64'(bus.ALU_result), 64'hA);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp_hold_alu", 64'(bus.ALU_result), 64'hA);
    chk("bp_hold_pc",  64'(bus.PC), 64'h200);
    chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_b_alu",   64'(bus.ALU_result), 64'hB);
    chk("bp_b_pc",    64'(bus.PC), 64'h204);
    chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_b_rdy",   64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_empty_v",    64'(bus.out_valid), 64'd0);
    chk("bp_empty_hold", 64'(bus.ALU_result), 64'hB);
    chk("bp_empty_wb",   64'(bus.WB_En), 64'd0);

    // Flush while FULL with dest 7 offered
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h300, 32'h1, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h304, 32'h2, 32'h0);
    tick();
    chk("fl_full_rdy", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h308, 32'h3, 32'h0);
    #1;
    chk("fl_rdy_in_flush_cycle", 64'(bus.in_ready), 64'd0);
    tick();
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_WB_En",     64'(bus.WB_En), 64'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl_no_dest7_v", 64'(bus.out_valid), 64'd0);
    chk("fl_rdy_back",   64'(bus.in_ready), 64'd1);

    // Flush in ONE drops the simultaneously accepted entry
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h400, 32'h4, 32'h0);
    tick();
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h404, 32'h5, 32'h0);
    #1;
    chk("fl1_rdy_in_flush_cycle", 64'(bus.in_ready), 64'd1);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("fl1_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl1_pc_kept",   64'(bus.PC), 64'h400);
    tick();
    chk("fl1_still_empty", 64'(bus.out_valid), 64'd0);

    // Register-0 write squashed
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd0, 32'h500, 32'h6, 32'h7);
    tick();
    chk("sq_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sq_WB_En",     64'(bus.WB_En), 64'd0);
    chk("sq_MEM_R_En",  64'(bus.MEM_R_En), 64'd1);

    // Load result selected for forwarding
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h504, 32'h33, 32'h55);
    tick();
    chk("fw_WB_En",    64'(bus.WB_En), 64'd1);
    chk("fw_dest",     64'(bus.dest), 64'd4);
    chk("fw_Mem_Data", 64'(bus.Mem_Data), 64'h55);
`ifdef MEM_WB_FWD_EN
    chk("fwd_value_mem", 64'(bus.fwd_value), 64'h55);
    chk("fwd_dest",      64'(bus.fwd_dest), 64'd4);
    chk("fwd_valid",     64'(bus.fwd_valid), 64'd1);
`endif
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h508, 32'h33, 32'h55);
    tick();
    chk("fw_alu_MEM_R_En", 64'(bus.MEM_R_En), 64'd0);
    chk("fw_alu_ALU",      64'(bus.ALU_result), 64'h33);
`ifdef MEM_WB_FWD_EN
    chk("fwd_value_alu", 64'(bus.fwd_value), 64'h33);
`endif

    // Reset while FULL discards both slots
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h600, 32'h77, 32'h0);
    tick();
    chk("mrst_full_rdy", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_ALU",       64'(bus.ALU_result), 64'd0);
    chk("mrst_in_ready",  64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("mrst_after_v",   64'(bus.out_valid), 64'd0);
    chk("mrst_after_rdy", 64'(bus.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
